vi_frame_sync: RTL
==================

# vi_frame_sync

Receive-side frame synchronizer for the VI pulse train: the train carries one pulse per period, with one pulse suppressed every PERIODS periods as the frame marker. The block measures the pulse period, detects the missing-pulse gap, verifies it recurs at the correct position, and then provides a frame strobe, slot index, lock flag and error strobe to the downstream deframing logic. It sits directly behind the VI input pin, in the system clock domain.

## Interface
- PERIODS, 40: input periods per frame, including the suppressed one. Pulses per frame = PERIODS-1.
- CNT_W, 12: width of the interval counter and period register.
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  reset; one clock; reset is asynchronous and active-high.
- iVI  in  1  asynchronous VI pulse train.
- oFrame  out  1  one-cycle strobe on the slot-0 pulse while locked; reset 0.
- oSlot  out  6  index of the last detected pulse, 0..PERIODS-2; held 0 in SEARCH; reset 0.
- oLock  out  1  high in LOCK; reset 0.
- oErr  out  1  one-cycle strobe on any framing violation or timeout; reset 0.
- oPeriod  out  CNT_W  current reference period P in clk cycles; reset 0.

## Operation
- iVI passes through a 2-flop synchronizer, then a third flop for edge detection. Only rising edges are used.
- Interval counter `cnt`:
  - increments every cycle and saturates at 2^CNT_W-1;
  - on a detected edge, interval I = cnt is captured and cnt <= 1.
- Period reference:
  - `pvalid` is set after the first captured interval, with P <= I.
  - Afterward, P <= I on every interval classified NORMAL.
- Classification of I when pvalid (compare in CNT_W+2 bits, no overflow):
  - GLITCH if 2*I < P;
  - GAP if 2*I > 3*P;
  - otherwise NORMAL.
- State machine, states SEARCH / VERIFY / LOCK:
  - **SEARCH:** GAP -> VERIFY with slot=0. NORMAL increments slot internally; oSlot stays 0. GLITCH clears pvalid.
  - **VERIFY / LOCK, NORMAL with slot < PERIODS-2:** slot+1.
  - **VERIFY / LOCK, GAP with slot == PERIODS-2:** slot=0; VERIFY -> LOCK. oFrame=1 on this edge in both cases.
  - **VERIFY, GAP with slot != PERIODS-2:** stay VERIFY, slot=0, oErr=1.
  - **LOCK, GAP with slot != PERIODS-2:** -> SEARCH, oErr=1.
  - **VERIFY / LOCK, NORMAL with slot == PERIODS-2 (gap missing):** -> SEARCH, oErr=1.
  - **VERIFY / LOCK, GLITCH:** -> SEARCH, oErr=1, pvalid cleared.
- Timeout: in VERIFY or LOCK, cnt reaching 3*P with no edge -> SEARCH, oErr=1, pvalid cleared, in that same cycle. In any state, a saturated cnt clears pvalid.
- Entering SEARCH forces oSlot=0 and oLock=0 and clears the internal slot.

## Timing
- Latency: an iVI rising edge first sampled at clk edge k produces oFrame/oSlot/oErr updates at edge k+2. Outputs are registered.
- oFrame and oErr are exactly one cycle wide.
- oLock rises in the same cycle as the first oFrame. It falls in the cycle of the oErr that drops lock.
- Lock acquisition needs two consecutive correctly spaced gaps, i.e. at least one full frame after the first gap.
- Asynchronous rst mid-frame clears all state, including pvalid, P and the synchronizer flops. Re-acquisition starts from SEARCH.
- Simultaneous timeout threshold and edge: the edge wins; the interval is classified normally.

## Test plan
- **Clean train:** P=16 clk (8 high / 8 low), PERIODS=40, 3 frames.
  - oPeriod=16.
  - oLock rises on the 2nd gap edge.
  - oFrame every 640 clk thereafter.
  - oSlot runs 0..38; no oErr.
- **Early gap:** locked, then a gap inserted at slot 20.
  - oErr pulse, oLock=0 on that edge.
  - Relock after the following two correct gaps.
- **Missing gap:** locked, then the suppressed pulse is restored.
  - At the edge after slot 38: oErr=1, oLock=0, oSlot=0.
- **Stuck input:** locked, then iVI held low.
  - oErr and loss of lock exactly 48 clk after the last edge.
  - No further strobes.
- **Glitch:** a 2-clk pulse inserted mid-period while locked.
  - oErr, SEARCH, pvalid cleared.
  - Recovery to lock within 2 frames plus 1 interval.
- **Async reset:** rst asserted mid-frame while locked.
  - All outputs 0 immediately, without waiting for clk.
  - Release leads to normal reacquisition.

Source files
------------

// File: rtl/vi_frame_sync.sv
// Frame synchronizer for the VI pulse train. It measures the pulse period and locks onto the
// recurring missing-pulse gap. Its outputs are a frame strobe, a slot index, a lock flag and an error strobe.
module vi_frame_sync #(
   parameter int PERIODS = 40,
   parameter int CNT_W   = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             iVI,
   output logic             oFrame,
   output logic [5:0]       oSlot,
   output logic             oLock,
   output logic             oErr,
   output logic [CNT_W-1:0] oPeriod
);

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      VERIFY = 2'd1,
      LOCK   = 2'd2
   } state_t;

   localparam logic [5:0] LAST_SLOT = 6'(PERIODS - 2);

   logic             sync1_r, sync2_r, sync3_r;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] period_r;
   logic             pvalid_r;
   logic [5:0]       slot_r;
   state_t           state_r;

   state_t           state_s;
   logic [5:0]       slot_s;
   logic             pvalid_s;
   logic [CNT_W-1:0] period_s;
   logic             frame_s;
   logic             err_s;

   logic             edge_s;
   logic             sat_s;
   logic             glitch_s;
   logic             gap_s;
   logic             timeout_s;
   logic [CNT_W+1:0] cnt_w_s;
   logic [CNT_W+1:0] i2_s;
   logic [CNT_W+1:0] p_w_s;
   logic [CNT_W+1:0] p3_s;

   // Interval classification uses two extra bits so that 2*I and 3*P cannot overflow.
   assign edge_s    = sync2_r & ~sync3_r;
   assign sat_s     = (cnt_r == {CNT_W{1'b1}});
   assign cnt_w_s   = {2'b00, cnt_r};
   assign i2_s      = {1'b0, cnt_r, 1'b0};
   assign p_w_s     = {2'b00, period_r};
   assign p3_s      = p_w_s + {1'b0, period_r, 1'b0};
   assign glitch_s  = (i2_s < p_w_s);
   assign gap_s     = (i2_s > p3_s);
   assign timeout_s = sat_s | (pvalid_r & (cnt_w_s >= p3_s));

   // Next-state, slot and strobe decode; a detected edge takes priority over the timeout.
   always_comb begin
      state_s  = state_r;
      slot_s   = slot_r;
      pvalid_s = pvalid_r;
      period_s = period_r;
      frame_s  = 1'b0;
      err_s    = 1'b0;
      if (edge_s) begin
         if (!pvalid_r) begin
            pvalid_s = 1'b1;
            period_s = cnt_r;
            state_s  = SEARCH;
            err_s    = (state_r != SEARCH);
         end else begin
            if (!glitch_s && !gap_s) begin
               period_s = cnt_r;
            end else begin
               period_s = period_r;
            end
            case (state_r)
               SEARCH: begin
                  if (glitch_s) begin
                     pvalid_s = 1'b0;
                  end else if (gap_s) begin
                     state_s = VERIFY;
                     slot_s  = 6'd0;
                  end else begin
                     slot_s = slot_r + 6'd1;
                  end
               end
               VERIFY, LOCK: begin
                  if (glitch_s) begin
                     state_s  = SEARCH;
                     err_s    = 1'b1;
                     pvalid_s = 1'b0;
                  end else if (gap_s) begin
                     if (slot_r == LAST_SLOT) begin
                        state_s = LOCK;
                        slot_s  = 6'd0;
                        frame_s = 1'b1;
                     end else if (state_r == VERIFY) begin
                        slot_s = 6'd0;
                        err_s  = 1'b1;
                     end else begin
                        state_s = SEARCH;
                        err_s   = 1'b1;
                     end
                  end else if (slot_r < LAST_SLOT) begin
                     slot_s = slot_r + 6'd1;
                  end else begin
                     state_s = SEARCH;
                     err_s   = 1'b1;
                  end
               end
               default: begin
                  state_s = SEARCH;
                  slot_s  = 6'd0;
               end
            endcase
         end
      end else if (timeout_s && (state_r != SEARCH)) begin
         state_s  = SEARCH;
         err_s    = 1'b1;
         pvalid_s = 1'b0;
      end else if (sat_s) begin
         pvalid_s = 1'b0;
      end else begin
         pvalid_s = pvalid_r;
      end
   end

   // Input synchronizer, edge-detect flop and saturating interval counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_r <= 1'b0;
         sync2_r <= 1'b0;
         sync3_r <= 1'b0;
         cnt_r   <= {CNT_W{1'b0}};
      end else begin
         sync1_r <= iVI;
         sync2_r <= sync1_r;
         sync3_r <= sync2_r;
         if (edge_s) begin
            cnt_r <= CNT_W'(1);
         end else if (!sat_s) begin
            cnt_r <= cnt_r + CNT_W'(1);
         end else begin
            cnt_r <= cnt_r;
         end
      end
   end

   // Framing state and registered outputs; entering SEARCH clears the slot.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r  <= SEARCH;
         slot_r   <= 6'd0;
         pvalid_r <= 1'b0;
         period_r <= {CNT_W{1'b0}};
         oFrame   <= 1'b0;
         oErr     <= 1'b0;
         oLock    <= 1'b0;
         oSlot    <= 6'd0;
         oPeriod  <= {CNT_W{1'b0}};
      end else begin
         state_r  <= state_s;
         slot_r   <= ((state_s == SEARCH) && (state_r != SEARCH)) ? 6'd0 : slot_s;
         pvalid_r <= pvalid_s;
         period_r <= period_s;
         oFrame   <= frame_s;
         oErr     <= err_s;
         oLock    <= (state_s == LOCK);
         oSlot    <= (state_s == SEARCH) ? 6'd0 : slot_s;
         oPeriod  <= period_s;
      end
   end

endmodule
